instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/proc_pkg.sv | 11 +
 rtl/pc_reg.sv | 25 ++
 rtl/instr_fetch.sv | 91 +++++++++
 tb/tb_instr_fetch.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor constants: address width, default instruction width, opcodes.
package proc_pkg;

  localparam int unsigned ADDR_WIDTH    = 16;
  localparam int unsigned DEF_ROM_WIDTH = 21;
  localparam int unsigned OPCODE_WIDTH  = 5;

  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 5'b01001;
  localparam logic [OPCODE_WIDTH-1:0] OP_JOV = 5'b01011;

endpackage : proc_pkg

// File: rtl/pc_reg.sv
// Fetch address register: load wins over increment, otherwise hold; wraps modulo 2^16.
module pc_reg
  import proc_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] addr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= RESET_ADDR;
    end else if (load) begin
      addr <= load_addr;
    end else if (inc) begin
      addr <= addr + ADDR_WIDTH'(1);
    end
  end

endmodule : pc_reg

// File: rtl/instr_fetch.sv
// Instruction fetch stage: IR/PC capture with decode handshake and jump redirect.
// Define FETCH_HALT_DETECT_EN to stop fetch permanently on an accepted self-jump.
module instr_fetch
  import proc_pkg::*;
#(
  parameter int unsigned           ROM_WIDTH  = DEF_ROM_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = 16'h0000
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [ROM_WIDTH-1:0]  data,
  output logic [ROM_WIDTH-1:0]  IR,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  input  logic                  jmp_req,
  input  logic [ADDR_WIDTH-1:0] jmp_addr,
  output logic                  halted
);

  logic                  halt_c;
  logic                  load_c;
  logic                  capture_c;
  logic [ROM_WIDTH-1:0]  ir_d;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic                  valid_d;

  pc_reg #(
    .RESET_ADDR (RESET_ADDR)
  ) u_pc_reg (
    .clk       (CLK),
    .rst       (RST),
    .load      (load_c),
    .load_addr (jmp_addr),
    .inc       (capture_c),
    .addr      (ADDR)
  );

`ifdef FETCH_HALT_DETECT_EN
  logic halted_d;
`endif

  // Priority: halt on self-jump, then redirect, then capture, else hold.
  always_comb begin
    halt_c = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
    halt_c = ir_valid & ir_ready & !halted
           & (IR[ROM_WIDTH-1 -: OPCODE_WIDTH] == OP_JMP)
           & (IR[ADDR_WIDTH-1:0] == PC);
    halted_d = halted | halt_c;
`endif
    load_c    = jmp_req & !halted & !halt_c;
    capture_c = (!ir_valid | ir_ready) & !jmp_req & !halted & !halt_c;
    ir_d      = IR;
    pc_d      = PC;
    valid_d   = ir_valid;
    if (halt_c || load_c) begin
      valid_d = 1'b0;
    end else if (capture_c) begin
      ir_d    = data;
      pc_d    = ADDR;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      IR       <= '0;
      PC       <= '0;
      ir_valid <= 1'b0;
    end else begin
      IR       <= ir_d;
      PC       <= pc_d;
      ir_valid <= valid_d;
    end
  end

`ifdef FETCH_HALT_DETECT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      halted <= 1'b0;
    end else begin
      halted <= halted_d;
    end
  end
`else
  assign halted = 1'b0;
`endif

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized traffic
// against a cycle model; follows FETCH_HALT_DETECT_EN when it is defined.
module tb_instr_fetch;

  localparam int unsigned RW = 21;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [15:0]   ADDR;
  logic [RW-1:0] data;
  logic [RW-1:0] IR;
  logic [15:0]   PC;
  logic          ir_valid;
  logic          ir_ready = 1'b0;
  logic          jmp_req  = 1'b0;
  logic [15:0]   jmp_addr = 16'h0000;
  logic          halted;

  int compared   = 0;
  int mismatched = 0;

  // reference state
  logic [15:0]   m_addr  = 16'h0000;
  logic [RW-1:0] m_ir    = '0;
  logic [15:0]   m_pc    = 16'h0000;
  logic          m_valid = 1'b0;
  logic          m_halt  = 1'b0;

  instr_fetch #(
    .ROM_WIDTH  (RW),
    .RESET_ADDR (16'h0000)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ADDR     (ADDR),
    .data     (data),
    .IR       (IR),
    .PC       (PC),
    .ir_valid (ir_valid),
    .ir_ready (ir_ready),
    .jmp_req  (jmp_req),
    .jmp_addr (jmp_addr),
    .halted   (halted)
  );

  always #5 CLK = ~CLK;

  // Program memory: word 0 and the self-jump at 10 are fixed, the rest never decode as JMP.
  function automatic logic [RW-1:0] rom_word(input logic [15:0] a);
    if (a == 16'd0)  return 21'b111010000000000000001;
    if (a == 16'd10) return 21'b010010000000000001010;
    return {5'b11000, a ^ 16'hA5C3};
  endfunction

  always_comb data = rom_word(ADDR);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ADDR"},     32'(ADDR),     32'(m_addr));
    chk({tag, ".IR"},       32'(IR),       32'(m_ir));
    chk({tag, ".PC"},       32'(PC),       32'(m_pc));
    chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(m_valid));
    chk({tag, ".halted"},   32'(halted),   32'(m_halt));
  endtask

  task automatic model_reset();
    m_addr = 16'h0000; m_ir = '0; m_pc = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
  endtask

  // One clock edge of the fetch rules.
  task automatic model_edge(input logic rdy, input logic jr, input logic [15:0] ja);
    logic self_jmp;
    self_jmp = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
    self_jmp = m_valid && rdy && (m_ir[20:16] == 5'b01001) && (m_ir[15:0] == m_pc);
`endif
    if (m_halt) begin
      m_halt = 1'b1;
    end else if (self_jmp) begin
      m_halt  = 1'b1;
      m_valid = 1'b0;
    end else if (jr) begin
      m_addr  = ja;
      m_valid = 1'b0;
    end else if (!m_valid || rdy) begin
      m_ir    = rom_word(m_addr);
      m_pc    = m_addr;
      m_valid = 1'b1;
      m_addr  = m_addr + 16'd1;
    end
  endtask

  // Called at a falling edge: drive, advance one rising edge, check at the next falling edge.
  task automatic step(input string tag, input logic rdy, input logic jr, input logic [15:0] ja);
    ir_ready = rdy;
    jmp_req  = jr;
    jmp_addr = ja;
    model_edge(rdy, jr, ja);
    @(posedge CLK);
    @(negedge CLK);
    check_all(tag);
  endtask

  task automatic reset_between_edges(input string tag);
    jmp_req  = 1'b1;
    jmp_addr = 16'h0042;
    #1 RST = 1'b1;
    #1;
    chk({tag, ".ADDR"},     32'(ADDR),     32'h0);
    chk({tag, ".IR"},       32'(IR),       32'h0);
    chk({tag, ".PC"},       32'(PC),       32'h0);
    chk({tag, ".ir_valid"}, 32'(ir_valid), 32'h0);
    chk({tag, ".halted"},   32'(halted),   32'h0);
    #1 RST = 1'b0;
    jmp_req = 1'b0;
    model_reset();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ja;
    logic        rdy;
    logic        jr;

    model_reset();
    @(negedge CLK);
    check_all("reset");
    RST = 1'b0;

    // straight-line fetch from reset
    step("cap0", 1'b1, 1'b0, 16'h0);
    chk("cap0.IR_literal", 32'(IR), 32'(21'b111010000000000000001));
    chk("cap0.ADDR_literal", 32'(ADDR), 32'h1);
    for (int i = 1; i <= 4; i++) step("seq", 1'b1, 1'b0, 16'h0);
    chk("seq.PC_literal", 32'(PC), 32'h4);

    // decode stall holds everything
    for (int i = 0; i < 3; i++) begin
      step("stall", 1'b0, 1'b0, 16'h0);
      chk("stall.PC_literal", 32'(PC), 32'h4);
      chk("stall.ADDR_literal", 32'(ADDR), 32'h5);
    end
    step("unstall", 1'b1, 1'b0, 16'h0);
    chk("unstall.PC_literal", 32'(PC), 32'h5);
    for (int i = 0; i < 4; i++) step("seq2", 1'b1, 1'b0, 16'h0);

    // redirect from PC 9 to 3: one bubble
    step("jmp3", 1'b1, 1'b1, 16'h0003);
    chk("jmp3.valid_literal", 32'(ir_valid), 32'h0);
    chk("jmp3.ADDR_literal", 32'(ADDR), 32'h3);
    step("jmp3_land", 1'b1, 1'b0, 16'h0);
    chk("jmp3_land.PC_literal", 32'(PC), 32'h3);

    // redirect to FFFF: address wraps on capture
    step("jmpF", 1'b0, 1'b1, 16'hFFFF);
    step("wrap", 1'b1, 1'b0, 16'h0);
    chk("wrap.ADDR_literal", 32'(ADDR), 32'h0);
    step("wrap2", 1'b1, 1'b0, 16'h0);
    chk("wrap2.PC_literal", 32'(PC), 32'h0);

    // self-jump at address 10
    step("jmp10", 1'b1, 1'b1, 16'd10);
    step("sj_cap", 1'b1, 1'b0, 16'h0);
    step("sj_acc", 1'b1, 1'b1, 16'h0003);
    for (int i = 0; i < 20; i++) begin
      step("post_sj", 1'($urandom_range(1)), 1'(i % 2), 16'($urandom_range(40)));
    end

    // asynchronous reset between edges while IR is valid
    reset_between_edges("rst_mid");
    step("rst_cap0", 1'b0, 1'b0, 16'h0);
    step("rst_cap1", 1'b1, 1'b0, 16'h0);
    step("rst_seq", 1'b1, 1'b0, 16'h0);
    reset_between_edges("rst_mid2");
    step("rst2_cap0", 1'b1, 1'b0, 16'h0);

    // randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      rdy = ($urandom_range(99) < 70);
      jr  = ($urandom_range(99) < 12);
      ja  = ($urandom_range(3) == 0) ? 16'(16'hFFF8 + 16'($urandom_range(7)))
                                     : 16'($urandom_range(24));
      if (i % 97 == 96) begin
        reset_between_edges("rnd_rst");
      end
      step("rnd", rdy, jr, ja);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_instr_fetch
